// File: rtl/datapath_controller.sv
// Multicycle control FSM for the 16-bit datapath: decodes the IR and drives every
// datapath control input, stalling in memory states until mem_ready.
module datapath_controller #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   instr,
  input  logic [7:0]         psr_flags,
  input  logic               mem_ready,
  output logic               PCEN,
  output logic               PSREN,
  output logic               nextInstruction,
  output logic               updateAddress,
  output logic               StoreReg,
  output logic               WriteData,
  output logic               regWrite,
  output logic               ZeroExtend,
  output logic               PCinstruction,
  output logic               SrcB,
  output logic               shiftType,
  output logic               JmpEN,
  output logic               BranchEN,
  output logic               JALEN,
  output logic [WIDTH-1:0]   shiftDir,
  output logic [7:0]         shiftAmt,
  output logic [REGBITS-1:0] ALUcond,
  output logic [1:0]         chooseResult,
  output logic [3:0]         ctrl_state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_SHIFT  = 4'd4,
    S_MEM_RD = 4'd5,
    S_LD_WB  = 4'd6,
    S_MEM_WR = 4'd7,
    S_JCOND  = 4'd8,
    S_JAL    = 4'd9,
    S_BCOND  = 4'd10,
    S_NOP    = 4'd11
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0] w_op;
  logic [3:0] w_cond;
  logic [3:0] w_ext;
  logic [4:0] w_shimm;
  logic [4:0] w_shmag;
  logic [4:0] w_lu_r;
  logic [4:0] w_lu_i;
  logic       w_cond_ok;
  logic       w_unused;

  assign w_op    = instr[15:12];
  assign w_cond  = instr[11:8];
  assign w_ext   = instr[7:4];
  assign w_shimm = instr[4:0];
  // Magnitude of the signed 5-bit shift immediate; -16 maps to 16 and still fits.
  assign w_shmag = w_shimm[4] ? (5'd0 - w_shimm) : w_shimm;
  assign w_unused = ^psr_flags[4:1];

  // {valid, ALU op} for a 4-bit opcode/ext code shared by R- and I-forms.
  function automatic logic [4:0] alu_lookup(input logic [3:0] c);
    case (c)
      4'b0101: alu_lookup = 5'h10;
      4'b1001: alu_lookup = 5'h11;
      4'b1011: alu_lookup = 5'h12;
      4'b0001: alu_lookup = 5'h13;
      4'b0010: alu_lookup = 5'h14;
      4'b0011: alu_lookup = 5'h15;
      4'b1101: alu_lookup = 5'h16;
      4'b1111: alu_lookup = 5'h17;
      default: alu_lookup = 5'h00;
    endcase
  endfunction

  assign w_lu_r = alu_lookup(w_ext);
  assign w_lu_i = alu_lookup(w_op);

  always_comb begin
    case (w_cond)
      4'b0000: w_cond_ok = psr_flags[6];
      4'b0001: w_cond_ok = !psr_flags[6];
      4'b0010: w_cond_ok = psr_flags[0];
      4'b0011: w_cond_ok = !psr_flags[0];
      4'b0110: w_cond_ok = psr_flags[7];
      4'b0111: w_cond_ok = !psr_flags[7];
      4'b1000: w_cond_ok = psr_flags[5];
      4'b1001: w_cond_ok = !psr_flags[5];
      4'b1100: w_cond_ok = !psr_flags[7] && !psr_flags[6];
      4'b1101: w_cond_ok = psr_flags[7] || psr_flags[6];
      4'b1110: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    PCEN            = 1'b0;
    PSREN           = 1'b0;
    nextInstruction = 1'b0;
    updateAddress   = 1'b0;
    StoreReg        = 1'b0;
    WriteData       = 1'b0;
    regWrite        = 1'b0;
    ZeroExtend      = 1'b0;
    PCinstruction   = 1'b0;
    SrcB            = 1'b0;
    shiftType       = 1'b0;
    JmpEN           = 1'b0;
    BranchEN        = 1'b0;
    JALEN           = 1'b0;
    shiftDir        = '0;
    shiftAmt        = 8'd0;
    ALUcond         = '0;
    chooseResult    = 2'b00;

    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          nextInstruction = 1'b1;
          PCEN            = 1'b1;
          w_next          = S_DECODE;
        end
      end

      S_DECODE: begin
        case (w_op)
          // LUI's code is only meaningful as an opcode, so ext 1111 is not an R-op.
          4'b0000: w_next = (w_lu_r[4] && w_ext != 4'b1111) ? S_EXEC_R : S_NOP;
          4'b0101, 4'b1001, 4'b1011, 4'b0001,
          4'b0010, 4'b0011, 4'b1101, 4'b1111: w_next = S_EXEC_I;
          4'b1000: w_next = (w_ext == 4'b0100 || w_ext[3:1] == 3'b000) ? S_SHIFT : S_NOP;
          4'b0100: begin
            case (w_ext)
              4'b0000: w_next = S_MEM_RD;
              4'b0100: w_next = S_MEM_WR;
              4'b1000: w_next = S_JAL;
              4'b1100: w_next = S_JCOND;
              default: w_next = S_NOP;
            endcase
          end
          4'b1100: w_next = S_BCOND;
          default: w_next = S_NOP;
        endcase
      end

      S_EXEC_R: begin
        ALUcond  = REGBITS'(w_lu_r[3:0]);
        regWrite = (w_lu_r[3:0] != 4'd2);
        PSREN    = (w_lu_r[3:0] <= 4'd2);
        w_next   = S_FETCH;
      end

      S_EXEC_I: begin
        SrcB       = 1'b1;
        ALUcond    = REGBITS'(w_lu_i[3:0]);
        regWrite   = (w_lu_i[3:0] != 4'd2);
        PSREN      = (w_lu_i[3:0] <= 4'd2);
        ZeroExtend = (w_lu_i[3:0] >= 4'd3) && (w_lu_i[3:0] <= 4'd5);
        w_next     = S_FETCH;
      end

      S_SHIFT: begin
        regWrite     = 1'b1;
        chooseResult = 2'b01;
        if (w_ext == 4'b0100) begin
          shiftType = 1'b1;
        end else begin
          shiftDir = {WIDTH{w_shimm[4]}};
          shiftAmt = {3'b000, w_shmag};
        end
        w_next = S_FETCH;
      end

      S_MEM_RD: begin
        updateAddress = 1'b1;
        if (mem_ready) w_next = S_LD_WB;
      end

      S_LD_WB: begin
        regWrite     = 1'b1;
        chooseResult = 2'b10;
        w_next       = S_FETCH;
      end

      S_MEM_WR: begin
        updateAddress = 1'b1;
        StoreReg      = 1'b1;
        WriteData     = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end

      S_JCOND: begin
        if (w_cond_ok) begin
          JmpEN = 1'b1;
          PCEN  = 1'b1;
        end
        w_next = S_FETCH;
      end

      S_JAL: begin
        JALEN        = 1'b1;
        JmpEN        = 1'b1;
        PCEN         = 1'b1;
        regWrite     = 1'b1;
        chooseResult = 2'b11;
        w_next       = S_FETCH;
      end

      S_BCOND: begin
        PCinstruction = 1'b1;
        SrcB          = 1'b1;
        if (w_cond_ok) begin
          BranchEN = 1'b1;
          PCEN     = 1'b1;
        end
        w_next = S_FETCH;
      end

      S_NOP:   w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
  end

  assign ctrl_state = r_state;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller: an instruction-level model expands each
// instruction into expected per-cycle outputs, compared against the DUT every cycle.
module tb_datapath_controller;

  localparam int B_PCEN = 13, B_PSREN = 12, B_NI = 11, B_UA = 10, B_SR = 9, B_WD = 8;
  localparam int B_RW = 7, B_ZE = 6, B_PCI = 5, B_SRCB = 4, B_STY = 3, B_JMP = 2;
  localparam int B_BR = 1, B_JAL = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [13:0] en;
    logic [15:0] sdir;
    logic [7:0]  samt;
    logic [3:0]  alu;
    logic [1:0]  res;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        only_st;
    logic        mid;
    logic        mr;
    logic [15:0] ins;
    logic [7:0]  fl;
    exp_t        e;
  } cyc_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic [7:0]  psr_flags;
  logic        mem_ready;
  logic PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData, regWrite;
  logic ZeroExtend, PCinstruction, SrcB, shiftType, JmpEN, BranchEN, JALEN;
  logic [15:0] shiftDir;
  logic [7:0]  shiftAmt;
  logic [3:0]  ALUcond;
  logic [1:0]  chooseResult;
  logic [3:0]  ctrl_state;

  datapath_controller #(.WIDTH(16), .REGBITS(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .psr_flags(psr_flags), .mem_ready(mem_ready),
    .PCEN(PCEN), .PSREN(PSREN), .nextInstruction(nextInstruction),
    .updateAddress(updateAddress), .StoreReg(StoreReg), .WriteData(WriteData),
    .regWrite(regWrite), .ZeroExtend(ZeroExtend), .PCinstruction(PCinstruction),
    .SrcB(SrcB), .shiftType(shiftType), .JmpEN(JmpEN), .BranchEN(BranchEN),
    .JALEN(JALEN), .shiftDir(shiftDir), .shiftAmt(shiftAmt), .ALUcond(ALUcond),
    .chooseResult(chooseResult), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  logic [43:0] act_o;
  assign act_o = {PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData,
                  regWrite, ZeroExtend, PCinstruction, SrcB, shiftType, JmpEN, BranchEN,
                  JALEN, shiftDir, shiftAmt, ALUcond, chooseResult};

  int    checks = 0;
  int    failures = 0;
  cyc_t  q[$];
  cyc_t  cur;
  logic  cur_valid = 1'b0;
  string cur_name = "";

  function automatic exp_t mk(input logic [3:0] st);
    exp_t e = '0;
    e.st = st;
    return e;
  endfunction

  // ALU op number for an opcode/ext code, -1 if the code is not an ALU operation.
  function automatic int alu_tab(input logic [3:0] c);
    case (c)
      4'h5: return 0;  4'h9: return 1;  4'hB: return 2;  4'h1: return 3;
      4'h2: return 4;  4'h3: return 5;  4'hD: return 6;  4'hF: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic bit cond_true(input logic [3:0] c, input logic [7:0] fl);
    bit z = fl[6], n = fl[7], cy = fl[0], f = fl[5];
    case (c)
      4'd0: return z;        4'd1: return !z;
      4'd2: return cy;       4'd3: return !cy;
      4'd6: return n;        4'd7: return !n;
      4'd8: return f;        4'd9: return !f;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input logic mr, input logic [15:0] ins, input logic [7:0] fl,
                      input exp_t e, input logic rst = 1'b0, input logic only_st = 1'b0);
    cyc_t c;
    c.rst = rst; c.only_st = only_st; c.mid = 1'b0; c.mr = mr;
    c.ins = ins; c.fl = fl; c.e = e;
    q.push_back(c);
  endtask

  // Expand one instruction into its cycle sequence: fw fetch waits, mw memory waits.
  task automatic add(input logic [15:0] ins, input logic [7:0] fl, input int fw, input int mw);
    exp_t e;
    logic [3:0] op = ins[15:12], ext = ins[7:4], cnd = ins[11:8];
    int a_r = alu_tab(ext), a_i = alu_tab(op);
    for (int i = 0; i < fw; i++) push(1'b0, ins, fl, mk(4'd0));
    e = mk(4'd0); e.en[B_PCEN] = 1; e.en[B_NI] = 1;
    push(1'b1, ins, fl, e);
    push(1'b0, ins, fl, mk(4'd1));
    if (op == 4'h0 && a_r >= 0 && a_r != 7) begin
      e = mk(4'd2); e.alu = 4'(a_r);
      e.en[B_RW] = (a_r != 2); e.en[B_PSREN] = (a_r <= 2);
      push(1'b0, ins, fl, e);
    end else if (op != 4'h0 && a_i >= 0) begin
      e = mk(4'd3); e.alu = 4'(a_i); e.en[B_SRCB] = 1;
      e.en[B_RW] = (a_i != 2); e.en[B_PSREN] = (a_i <= 2);
      e.en[B_ZE] = (a_i >= 3 && a_i <= 5);
      push(1'b0, ins, fl, e);
    end else if (op == 4'h8 && (ext == 4'h4 || ext <= 4'h1)) begin
      e = mk(4'd4); e.en[B_RW] = 1; e.res = 2'b01;
      if (ext == 4'h4) e.en[B_STY] = 1;
      else begin
        int v = int'(ins[4:0]);
        if (v >= 16) v -= 32;
        e.sdir = (v < 0) ? 16'hFFFF : 16'h0000;
        e.samt = 8'((v < 0) ? -v : v);
      end
      push(1'b0, ins, fl, e);
    end else if (op == 4'h4 && ext == 4'h0) begin
      e = mk(4'd5); e.en[B_UA] = 1;
      for (int i = 0; i < mw; i++) push(1'b0, ins, fl, e);
      push(1'b1, ins, fl, e);
      e = mk(4'd6); e.en[B_RW] = 1; e.res = 2'b10;
      push(1'b0, ins, fl, e);
    end else if (op == 4'h4 && ext == 4'h4) begin
      e = mk(4'd7); e.en[B_UA] = 1; e.en[B_SR] = 1; e.en[B_WD] = 1;
      for (int i = 0; i < mw; i++) push(1'b0, ins, fl, e);
      push(1'b1, ins, fl, e);
    end else if (op == 4'h4 && ext == 4'h8) begin
      e = mk(4'd9); e.en[B_JAL] = 1; e.en[B_JMP] = 1; e.en[B_PCEN] = 1; e.en[B_RW] = 1;
      e.res = 2'b11;
      push(1'b0, ins, fl, e);
    end else if (op == 4'h4 && ext == 4'hC) begin
      e = mk(4'd8);
      if (cond_true(cnd, fl)) begin e.en[B_JMP] = 1; e.en[B_PCEN] = 1; end
      push(1'b0, ins, fl, e);
    end else if (op == 4'hC) begin
      e = mk(4'd10); e.en[B_PCI] = 1; e.en[B_SRCB] = 1;
      if (cond_true(cnd, fl)) begin e.en[B_BR] = 1; e.en[B_PCEN] = 1; end
      push(1'b0, ins, fl, e);
    end else begin
      push(1'b0, ins, fl, mk(4'd11));
    end
  endtask

  task automatic pin_rec(input string nm, input int idx, input exp_t want);
    checks++;
    if (q[idx].e !== want) begin
      failures++;
      $display("FAIL pin_%s: model %h required %h", nm, q[idx].e, want);
    end
  endtask

  task automatic pin_len(input string nm, input int want);
    checks++;
    if (q.size() != want) begin
      failures++;
      $display("FAIL pin_%s_len: model %0d cycles required %0d", nm, q.size(), want);
    end
  endtask

  task automatic play(input string nm);
    cur_name = nm;
    foreach (q[i]) begin
      @(negedge clk);
      reset = q[i].rst; mem_ready = q[i].mr; instr = q[i].ins; psr_flags = q[i].fl;
      cur = q[i]; cur_valid = 1'b1;
      if (q[i].mid) begin
        #3 reset = 1'b1;
      end
    end
    q.delete();
  endtask

  task automatic run(input string nm, input logic [15:0] ins, input logic [7:0] fl,
                     input int fw, input int mw);
    add(ins, fl, fw, mw);
    play(nm);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      #2;
      if (cur_valid) begin
        checks++;
        if (ctrl_state !== cur.e.st) begin
          failures++;
          $display("FAIL %s state: got %0d want %0d", cur_name, ctrl_state, cur.e.st);
        end
        if (!cur.only_st) begin
          checks++;
          if (act_o !== {cur.e.en, cur.e.sdir, cur.e.samt, cur.e.alu, cur.e.res}) begin
            failures++;
            $display("FAIL %s outputs st=%0d: got %h want %h", cur_name, cur.e.st, act_o,
                     {cur.e.en, cur.e.sdir, cur.e.samt, cur.e.alu, cur.e.res});
          end
        end
        if (cur.mid) begin
          #2;
          checks++;
          if (WriteData !== 1'b0) begin
            failures++;
            $display("FAIL %s abort_writedata: got %b want 0", cur_name, WriteData);
          end
          checks++;
          if (ctrl_state !== 4'd0) begin
            failures++;
            $display("FAIL %s abort_state: got %0d want 0", cur_name, ctrl_state);
          end
        end
        $display("cycle %s st=%0d out=%h", cur_name, ctrl_state, act_o);
      end
    end
  endtask

  initial begin
    exp_t w;
    reset = 1'b1; mem_ready = 1'b1; instr = 16'h0000; psr_flags = 8'h00;
    fork
      compare_loop();
    join_none

    push(1'b1, 16'h0000, 8'h00, mk(4'd0), 1'b1, 1'b1);
    push(1'b1, 16'h0000, 8'h00, mk(4'd0), 1'b1, 1'b1);
    play("reset");

    // Model pins against hand-derived records.
    add(16'h0152, 8'h00, 0, 0);
    pin_len("add", 3);
    w = mk(4'd2); w.en = 14'h1080; pin_rec("add_exec", 2, w);
    play("ADD_R1_R2");

    add(16'h13F0, 8'h00, 0, 0);
    w = mk(4'd3); w.en = 14'h00D0; w.alu = 4'd3; pin_rec("andi_exec", 2, w);
    play("ANDI_R3_F0");

    add(16'h4204, 8'h00, 0, 2);
    pin_len("load", 6);
    w = mk(4'd6); w.en = 14'h0080; w.res = 2'b10; pin_rec("load_wb", 5, w);
    play("LOAD_R2_R4_wait2");

    add(16'hC0FE, 8'h40, 0, 0);
    w = mk(4'd10); w.en = 14'h2032; pin_rec("beq_taken", 2, w);
    play("BEQ_taken");
    add(16'hC0FE, 8'h00, 0, 0);
    w = mk(4'd10); w.en = 14'h0030; pin_rec("beq_not", 2, w);
    play("BEQ_not_taken");

    add(16'h801D, 8'h00, 0, 0);
    w = mk(4'd4); w.en = 14'h0080; w.res = 2'b01; w.sdir = 16'hFFFF; w.samt = 8'd3;
    pin_rec("shr3", 2, w);
    play("SHIFT_imm_-3");

    run("SUB_R",    16'h0193, 8'h00, 0, 0);
    run("CMP_R",    16'h01B3, 8'h00, 0, 0);
    run("AND_R",    16'h0113, 8'h00, 0, 0);
    run("OR_R",     16'h0123, 8'h00, 0, 0);
    run("XOR_R",    16'h0133, 8'h00, 0, 0);
    run("MOV_R",    16'h01D3, 8'h00, 0, 0);
    run("ADDI",     16'h5101, 8'h00, 0, 0);
    run("SUBI",     16'h9101, 8'h00, 0, 0);
    run("CMPI",     16'hB105, 8'h00, 0, 0);
    run("ORI",      16'h2155, 8'h00, 0, 0);
    run("XORI",     16'h3155, 8'h00, 0, 0);
    run("MOVI",     16'hD17F, 8'h00, 0, 0);
    run("LUI",      16'hF112, 8'h00, 0, 0);
    run("SHL_imm3", 16'h8103, 8'h00, 0, 0);
    run("SHR_16",   16'h8110, 8'h00, 0, 0);
    run("SH_reg",   16'h8143, 8'h00, 0, 0);
    run("STORE",    16'h4341, 8'h00, 0, 0);
    run("STORE_w1", 16'h4341, 8'h00, 0, 1);
    run("LOAD_w0",  16'h4204, 8'h00, 0, 0);
    run("JAL",      16'h4185, 8'h00, 0, 0);
    run("J_always", 16'h4EC3, 8'h00, 0, 0);
    run("JEQ_not",  16'h40C3, 8'h00, 0, 0);
    run("JGT_true", 16'h4CC3, 8'h00, 0, 0);
    run("JGT_false",16'h4CC3, 8'h80, 0, 0);
    run("J_never",  16'h44C3, 8'hFF, 0, 0);
    run("BCS",      16'hC205, 8'h01, 0, 0);
    run("BFS_not",  16'hC805, 8'h00, 0, 0);
    run("BLE_true", 16'hCD05, 8'h80, 0, 0);
    run("NOP_op7",  16'h7000, 8'h00, 0, 0);
    run("ADD_fw2",  16'h0152, 8'h00, 2, 0);

    // Reset asserted while a store is waiting on memory.
    add(16'h4344, 8'h00, 0, 3);
    q = q[0:2];
    q[2].mid = 1'b1;
    push(1'b1, 16'h4344, 8'h00, mk(4'd0), 1'b1, 1'b1);
    push(1'b1, 16'h4344, 8'h00, mk(4'd0), 1'b1, 1'b1);
    play("STORE_abort");
    run("ADD_after_abort", 16'h0152, 8'h00, 0, 0);

    @(negedge clk);
    cur_valid = 1'b0;
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
